// File: rtl/score_keeper.sv
// Two-player score keeper: counts rising goal edges, filters re-triggers
// with a holdoff window and declares a winner at WIN_SCORE.
module score_keeper #(
    parameter int WIN_SCORE      = 9,
    parameter int HOLDOFF_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       goal_left,
    input  logic       goal_right,
    input  logic       start,
    output logic [7:0] points,
    output logic       game_over,
    output logic       winner,
    output logic       point_scored
);

    localparam int CW = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_CYCLES - 1);
    localparam logic [3:0]    WIN_NIB   = 4'(WIN_SCORE);

    typedef enum logic [1:0] {IDLE, PLAY, HOLDOFF, OVER} state_t;

    state_t        state;
    logic [CW-1:0] hold_cnt;
    logic          goal_left_prev, goal_right_prev;
    logic [3:0]    left_score, right_score;
    logic          edge_l, edge_r;
    logic [3:0]    left_inc, right_inc;

    assign edge_l    = goal_left & ~goal_left_prev;
    assign edge_r    = goal_right & ~goal_right_prev;
    assign left_inc  = left_score + 4'd1;
    assign right_inc = right_score + 4'd1;
    assign points    = {left_score, right_score};

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            hold_cnt        <= '0;
            goal_left_prev  <= 1'b0;
            goal_right_prev <= 1'b0;
            left_score      <= '0;
            right_score     <= '0;
            game_over       <= 1'b0;
            winner          <= 1'b0;
            point_scored    <= 1'b0;
        end else begin
            goal_left_prev  <= goal_left;
            goal_right_prev <= goal_right;
            point_scored    <= 1'b0;

            // start wins over any goal edge in every state
            if (start) begin
                state       <= PLAY;
                hold_cnt    <= '0;
                left_score  <= '0;
                right_score <= '0;
                game_over   <= 1'b0;
                winner      <= 1'b0;
            end else begin
                case (state)
                    PLAY: begin
                        if (edge_l != edge_r) begin
                            point_scored <= 1'b1;
                            hold_cnt     <= '0;
                            if (edge_l) begin
                                left_score <= left_inc;
                                if (left_inc == WIN_NIB) begin
                                    state     <= OVER;
                                    game_over <= 1'b1;
                                    winner    <= 1'b0;
                                end else begin
                                    state <= HOLDOFF;
                                end
                            end else begin
                                right_score <= right_inc;
                                if (right_inc == WIN_NIB) begin
                                    state     <= OVER;
                                    game_over <= 1'b1;
                                    winner    <= 1'b1;
                                end else begin
                                    state <= HOLDOFF;
                                end
                            end
                        end
                    end
                    HOLDOFF: begin
                        if (hold_cnt == HOLD_LAST) begin
                            state    <= PLAY;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    IDLE, OVER: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter WIN_SCORE, default 9, points needed to win; legal range 1..9.
REQ-002 Parameter HOLDOFF_CYCLES, default 1_000_000, clock cycles during which goals are ignored after a counted point; legal range >= 1.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 goal_left  input  1  level; high while the ball is in the right goal, meaning the left player scores.
REQ-006 goal_right  input  1  level; high while the ball is in the left goal, meaning the right player scores.
REQ-007 start  input  1  single-cycle pulse that starts or restarts a game.
REQ-008 points  output  8  [7:4] left score, [3:0] right score; each nibble is BCD 0..9.
REQ-009 game_over  output  1  high while in OVER.
REQ-010 winner  output  1  0 means left won, 1 means right won; valid only while game_over is 1.
REQ-011 point_scored  output  1  one-cycle pulse when a point is counted.

Function
REQ-012 The block SHALL register goal_left and goal_right once (the _prev registers).
- edge_l = goal_left & ~goal_left_prev.
- edge_r = goal_right & ~goal_right_prev.
REQ-013 FSM states SHALL be IDLE, PLAY, HOLDOFF and OVER.
REQ-014 IDLE: scores held at 0; edges ignored; start -> PLAY.
REQ-015 PLAY with exactly one of edge_l or edge_r:
- The matching score increments by 1.
- point_scored = 1 for one cycle.
- Both take effect on the next clock edge, a latency of 1 cycle from the edge cycle.
REQ-016 PLAY with edge_l and edge_r in the same cycle: neither score changes, no point_scored pulse, state remains PLAY.
REQ-017 After an increment in PLAY:
- New score == WIN_SCORE -> OVER; game_over = 1; winner = side that scored.
- Otherwise -> HOLDOFF; holdoff counter loads 0.
REQ-018 HOLDOFF:
- Counter increments each cycle; all goal edges are ignored.
- When the counter reaches HOLDOFF_CYCLES-1 -> PLAY on the next edge.
- Exactly HOLDOFF_CYCLES cycles are spent in HOLDOFF.
REQ-019 OVER: scores, winner and game_over hold; goal edges ignored; start -> PLAY with both scores 0 and game_over = 0.
REQ-020 start in PLAY or HOLDOFF SHALL clear both scores and enter PLAY.
- Holdoff counter clears.
- start has priority over any goal edge in the same cycle; no point is counted.
REQ-021 A score nibble SHALL never exceed WIN_SCORE (<= 9), so a downstream 7-segment decoder always receives valid BCD.
REQ-022 Holdoff counter width: $clog2(HOLDOFF_CYCLES+1) bits; no wrap inside HOLDOFF.
REQ-023 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-024 On rst = 1 at a clock edge, the following values SHALL apply from the next cycle:
- state = IDLE
- points = 8'h00
- game_over = 0, winner = 0, point_scored = 0
- holdoff counter = 0
- goal_left_prev = 0, goal_right_prev = 0
REQ-025 rst SHALL override start and goal inputs in the same cycle.
REQ-026 rst asserted mid-game, in any state, SHALL abandon the game immediately.
REQ-027 A goal input held high across reset release SHALL produce an edge in IDLE, which is ignored.

Verification (WIN_SCORE=3, HOLDOFF_CYCLES=4 unless noted)
REQ-028 Basic point:
- Stimulus: rst, start; goal_left high for 10 cycles.
- Required: points = 8'h10 one cycle after the edge; a single point_scored pulse; holdoff lasts 4 cycles; no second point from the held level.
REQ-029 Win:
- Stimulus: three separated goal_right pulses, each after holdoff.
- Required: points 01, 02, 03; game_over = 1, winner = 1 after the third; further goals leave points = 8'h03.
REQ-030 Holdoff filter:
- Stimulus: goal_left pulse, then goal_right pulse 2 cycles later.
- Required: points = 8'h10 only; the goal_right pulse is ignored.
REQ-031 Simultaneous edges:
- Stimulus: goal_left and goal_right rise in the same PLAY cycle.
- Required: points unchanged, point_scored = 0, state PLAY.
REQ-032 Restart and reset:
- start coinciding with a goal edge in PLAY at 8'h21 -> points = 8'h00, no point_scored pulse.
- rst in OVER -> IDLE, all outputs 0; goals ignored until start.
REQ-033 WIN_SCORE=9 run: alternate goals to 9-8 -> points = 8'h98, winner = 0; neither nibble ever exceeds 9.
